// File: rtl/rt_pkg.sv
// Shared ray-tracer definitions: camera fixed-point format, pixel generator
// states and the anti-aliasing sub-pixel offset.
package rt_pkg;

  localparam int CAMERA_IW = 16;
  localparam int CAMERA_QW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rt_pixgen_state_e;

  // Quarter-pixel step in a format with qw fractional bits (qw >= 2).
  function automatic int AA_OFFSET_Q(input int qw);
    return 1 << (qw - 2);
  endfunction

endpackage

// File: rtl/rt_wrap_counter.sv
// Up-counter over 0..MAX-1 with synchronous clear; wrap_o flags the enabled
// step that returns the count to 0, so counters can be chained.
module rt_wrap_counter #(
  parameter  int MAX = 4,
  localparam int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] val_o,
  output logic         wrap_o
);

  logic [W-1:0] val_q, val_d;
  logic         at_max;

  assign at_max = (val_q == W'(MAX - 1));
  assign wrap_o = en_i & at_max;
  assign val_o  = val_q;

  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = '0;
    end else if (en_i) begin
      val_d = at_max ? '0 : val_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

endmodule

// File: rtl/rt_pixel_gen.sv
// Raster-order pixel coordinate generator for the ray generation unit.
// Define RT_PIXGEN_AA_EN for 4 samples per pixel on a 2x2 sub-pixel grid.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | issuing coordinate beats (valid_o high)
// DONE  | one-cycle done_o pulse after the last beat
module rt_pixel_gen
  import rt_pkg::*;
#(
  parameter  int IMG_W = 640,
  parameter  int IMG_H = 480,
  parameter  int IW    = CAMERA_IW,
  parameter  int QW    = CAMERA_QW,
  localparam int XW    = ($clog2(IMG_W) > 1) ? $clog2(IMG_W) : 1,
  localparam int YW    = ($clog2(IMG_H) > 1) ? $clog2(IMG_H) : 1,
  localparam int FW    = IW + QW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [XW-1:0] pix_x_o,
  output logic [YW-1:0] pix_y_o,
  output logic [1:0]    sample_o,
  output logic [FW-1:0] x_o,
  output logic [FW-1:0] y_o,
  output logic          last_o
);

  rt_pixgen_state_e state_q, state_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic          accept, clr;
  logic          smp_wrap, x_wrap, frame_end;
  logic          smp_last;
  logic [1:0]    smp;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [FW-1:0] x_fp, y_fp;

  assign accept = valid_q & ready_i;

`ifdef RT_PIXGEN_AA_EN
  localparam logic [FW-1:0] OFS = FW'(AA_OFFSET_Q(QW));

  rt_wrap_counter #(.MAX(4)) u_smp_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr),
    .en_i   (accept),
    .val_o  (smp),
    .wrap_o (smp_wrap)
  );
  assign smp_last = (smp == 2'd3);
`else
  assign smp      = 2'd0;
  assign smp_wrap = accept;
  assign smp_last = 1'b1;
`endif

  rt_wrap_counter #(.MAX(IMG_W)) u_x_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr),
    .en_i   (smp_wrap),
    .val_o  (px),
    .wrap_o (x_wrap)
  );

  // The row counter wraps exactly on the accepted final beat of the frame.
  rt_wrap_counter #(.MAX(IMG_H)) u_y_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr),
    .en_i   (x_wrap),
    .val_o  (py),
    .wrap_o (frame_end)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (frame_end) begin
          state_d = DONE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    x_fp = FW'(px) << QW;
    y_fp = FW'(py) << QW;
`ifdef RT_PIXGEN_AA_EN
    x_fp = x_fp + (smp[0] ? OFS : -OFS);
    y_fp = y_fp + (smp[1] ? OFS : -OFS);
`endif
  end

  // Payload is forced to zero outside a valid beat so reset clears every output.
  assign valid_o  = valid_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign pix_x_o  = valid_q ? px : '0;
  assign pix_y_o  = valid_q ? py : '0;
  assign sample_o = valid_q ? smp : 2'd0;
  assign x_o      = valid_q ? x_fp : '0;
  assign y_o      = valid_q ? y_fp : '0;
  assign last_o   = valid_q & smp_last & (px == XW'(IMG_W - 1)) & (py == YW'(IMG_H - 1));

endmodule

// File: tb/tb_rt_pixel_gen.sv
// Scoreboard bench for rt_pixel_gen: a 4x2 frame instance and a 1x1 instance.
module tb_rt_pixel_gen;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int IW = 16;
  localparam int QW = 16;
`ifdef RT_PIXGEN_AA_EN
  localparam int NS  = 4;
  localparam int OFF = 1 << (QW - 2);
`else
  localparam int NS  = 1;
  localparam int OFF = 0;
`endif
  localparam int NB = W * H * NS;

  logic clk, rst_n, start, abort, ready;
  logic busy, done, valid, last;
  logic [1:0] px;
  logic [0:0] py;
  logic [1:0] smp;
  logic [31:0] xo, yo;

  logic start_b, ready_b;
  logic busy_b, done_b, valid_b, last_b;
  logic [0:0] px_b, py_b;
  logic [1:0] smp_b;
  logic [31:0] xo_b, yo_b;

  rt_pixel_gen #(.IMG_W(W), .IMG_H(H), .IW(IW), .QW(QW)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .valid_o(valid), .ready_i(ready),
    .pix_x_o(px), .pix_y_o(py), .sample_o(smp), .x_o(xo), .y_o(yo),
    .last_o(last)
  );

  rt_pixel_gen #(.IMG_W(1), .IMG_H(1), .IW(IW), .QW(QW)) u_dut_1x1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .abort_i(1'b0),
    .busy_o(busy_b), .done_o(done_b), .valid_o(valid_b), .ready_i(ready_b),
    .pix_x_o(px_b), .pix_y_o(py_b), .sample_o(smp_b), .x_o(xo_b), .y_o(yo_b),
    .last_o(last_b)
  );

  typedef struct {
    int          px;
    int          py;
    int          s;
    logic [31:0] xo;
    logic [31:0] yo;
    logic        last;
  } beat_t;

  beat_t q[$];
  beat_t mon_e;
  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input int idx, input int w, input int h);
    beat_t b;
    int p, ox, oy;
    b.s  = idx % NS;
    p    = idx / NS;
    b.px = p % w;
    b.py = p / w;
    ox   = (NS == 4) ? (((b.s & 1) != 0) ? OFF : -OFF) : 0;
    oy   = (NS == 4) ? (((b.s & 2) != 0) ? OFF : -OFF) : 0;
    b.xo = 32'(b.px * (1 << QW) + ox);
    b.yo = 32'(b.py * (1 << QW) + oy);
    b.last = (idx == w * h * NS - 1);
    return b;
  endfunction

  task automatic push(input int n);
    for (int i = 0; i < n; i++) q.push_back(mk(i, W, H));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc();
      seen = done;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  // Scoreboard: every handshake must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (q.size() == 0) begin
        chk("beat_expected", 64'(q.size()), 64'd1);
      end else begin
        mon_e = q.pop_front();
        chk("pix_x", 64'(px), 64'(mon_e.px));
        chk("pix_y", 64'(py), 64'(mon_e.py));
        chk("sample", 64'(smp), 64'(mon_e.s));
        chk("x_o", 64'(xo), 64'(mon_e.xo));
        chk("y_o", 64'(yo), 64'(mon_e.yo));
        chk("last", 64'(last), 64'(mon_e.last));
      end
    end
  end

  initial begin
    beat_t e;
    logic found;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
    start_b = 1'b0; ready_b = 1'b1;
    #12;
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_x_o", 64'(xo), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Full frame walk
    push(NB);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t1_valid_latency", 64'(valid), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1_done_seen");
    chk("t1_queue_empty", 64'(q.size()), 64'd0);
    chk("t1_valid_in_done", 64'(valid), 64'd0);
    chk("t1_busy_in_done", 64'(busy), 64'd0);
    cyc();
    chk("t1_done_pulse", 64'(done), 64'd0);

    // Backpressure at (2,0)
    push(NB);
    start = 1'b1;
    cyc();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (valid && px == 2'd2 && py == 1'b0 && smp == 2'd0) found = 1'b1;
      else cyc();
    end
    chk("t2_reached_2_0", 64'(found), 64'd1);
    ready = 1'b0;
    e = mk(2 * NS, W, H);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_valid_held", 64'(valid), 64'd1);
      chk("t2_x_stable", 64'(xo), 64'(e.xo));
      chk("t2_y_stable", 64'(yo), 64'(e.yo));
    end
    ready = 1'b1;
    wait_done("t2_done_seen");
    chk("t2_queue_empty", 64'(q.size()), 64'd0);
    cyc();

    // Ignored start in RUN, abort on beat 5, restart
    push(5);
    start = 1'b1;
    cyc();
    for (int k = 1; k <= 4; k++) begin
      start = (k == 2);
      cyc();
    end
    start = 1'b0;
    abort = 1'b1;
    chk("t3_valid_before_abort", 64'(valid), 64'd1);
    cyc();
    abort = 1'b0;
    chk("t3_valid_after_abort", 64'(valid), 64'd0);
    chk("t3_busy_after_abort", 64'(busy), 64'd0);
    chk("t3_no_done", 64'(done), 64'd0);
    cyc();
    chk("t3_no_done_later", 64'(done), 64'd0);
    chk("t3_queue_empty", 64'(q.size()), 64'd0);
    push(NB);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done("t3_restart_done");
    chk("t3_restart_queue_empty", 64'(q.size()), 64'd0);
    cyc();

    // Reset mid-frame at beat 3
    push(2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t4_valid", 64'(valid), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_done", 64'(done), 64'd0);
    chk("t4_pix", 64'({px, py, smp}), 64'd0);
    chk("t4_xy", 64'({xo, yo}), 64'd0);
    chk("t4_last", 64'(last), 64'd0);
    chk("t4_queue_empty", 64'(q.size()), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t4_idle_valid", 64'(valid), 64'd0);
    chk("t4_idle_busy", 64'(busy), 64'd0);

    // Degenerate 1x1 frame
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    for (int s = 0; s < NS; s++) begin
      e = mk(s, 1, 1);
      chk("t6_valid", 64'(valid_b), 64'd1);
      chk("t6_pix", 64'({px_b, py_b}), 64'd0);
      chk("t6_sample", 64'(smp_b), 64'(e.s));
      chk("t6_x_o", 64'(xo_b), 64'(e.xo));
      chk("t6_last", 64'(last_b), 64'(e.last));
      cyc();
    end
    chk("t6_done", 64'(done_b), 64'd1);
    chk("t6_valid_off", 64'(valid_b), 64'd0);
    cyc();
    chk("t6_done_pulse", 64'(done_b), 64'd0);
    chk("t6_busy", 64'(busy_b), 64'd0);
    chk("t6_idle_valid", 64'(valid_b), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
